// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the icache, dcache and RAM signals seen by mem_arbiter.
// slave  - the arbiter's view (requests and RAM status in, RAM strobes and waits out).
// master - the caches' and RAM's view of the same wires.
interface mem_arbiter_if;
  // icache side
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  // dcache side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache and the dcache.
// The owner keeps the RAM for as long as its request stays high, so dcache
// block transfers and writebacks are never interleaved with icache reads.
// On release the other requester is granted directly (no idle cycle).
// Optional feature: define ARB_ROUND_ROBIN_EN to break simultaneous-request
// ties in favour of the requester that was not served last; otherwise the
// dcache always wins a tie.
module mem_arbiter (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2
  } owner_t;

  owner_t owner_q, owner_d;
  logic   last_q, last_d;   // 1 = dcache was granted most recently
  logic   dreq;
  logic   access;
  logic   d_wins_tie;

  assign dreq   = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == RAM_ACCESS);

`ifdef ARB_ROUND_ROBIN_EN
  assign d_wins_tie = ~last_q;
`else
  assign d_wins_tie = 1'b1;
`endif

  // Owner and last-served registers; reset drops any transfer in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next owner: hold while the owner requests, hand over directly on release.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    unique case (owner_q)
      OWN_D: begin
        if (!dreq) owner_d = bus.iREN ? OWN_I : OWN_NONE;
      end
      OWN_I: begin
        if (!bus.iREN) owner_d = dreq ? OWN_D : OWN_NONE;
      end
      default: begin
        if (dreq && (!bus.iREN || d_wins_tie)) owner_d = OWN_D;
        else if (bus.iREN)                    owner_d = OWN_I;
        else                                  owner_d = OWN_NONE;
      end
    endcase
    if (owner_d == OWN_D)      last_d = 1'b1;
    else if (owner_d == OWN_I) last_d = 1'b0;
  end

  // RAM strobes and cache waits follow the current owner; ERROR just stalls.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    unique case (owner_q)
      OWN_D: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dwait    = ~access;
      end
      OWN_I: begin
        bus.ramREN   = bus.iREN;
        bus.ramaddr  = bus.iaddr;
        bus.iwait    = ~access;
      end
      default: begin
      end
    endcase
  end

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

endmodule
